// File: rtl/core_lsu.sv
// -----------------------------------------------------------------------------
// core_lsu : load/store unit between the MEM stage and an XLEN-wide data bus.
//
// Accepts one access request at a time, aligns it onto the bus (byte enables
// plus lane-shifted store data), waits for bus_ack with an optional timeout and
// returns lane-extracted, sign/zero-extended load data or an error code.
//
// Ports
//   clk          : clock, rising edge
//   rst          : asynchronous active-low reset
//   req_valid    : access request strobe (held by requester until req_ready)
//   req_ready    : LSU idle and able to accept a request
//   req_wr       : 1 = store, 0 = load
//   req_size     : 00 byte, 01 half, 10 word, 11 double (XLEN=64 only)
//   req_sign_ext : loads sign-extend when 1, zero-extend when 0
//   req_addr     : byte address
//   req_wdata    : right-justified store data
//   bus_addr     : bus-word aligned address
//   bus_rd_en    : bus read strobe
//   bus_wr_en    : bus write strobe
//   bus_be       : byte enables
//   bus_wdata    : lane-shifted store data
//   bus_rdata    : read data, valid with bus_ack
//   bus_ack      : bus access complete
//   rsp_valid    : one-cycle response pulse
//   rsp_rdata    : extended load data (0 for stores and errors)
//   rsp_err      : 00 ok, 01 misaligned/illegal size, 10 timeout
// -----------------------------------------------------------------------------
module core_lsu #(
    parameter int XLEN    = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [1:0]        req_size,
    input  logic              req_sign_ext,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic [ADDR_W-1:0] bus_addr,
    output logic              bus_rd_en,
    output logic              bus_wr_en,
    output logic [XLEN/8-1:0] bus_be,
    output logic [XLEN-1:0]   bus_wdata,
    input  logic [XLEN-1:0]   bus_rdata,
    input  logic              bus_ack,
    output logic              rsp_valid,
    output logic [XLEN-1:0]   rsp_rdata,
    output logic [1:0]        rsp_err
);

    localparam int BE_W  = XLEN / 8;
    localparam int OFF_W = $clog2(BE_W);
    // Counter only has to reach TIMEOUT-1 before the FSM leaves BUS.
    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_ALIGN   = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUS  = 2'b01,
        ST_RESP = 2'b10
    } state_e;

    // -------------------------------------------------------------------------
    // Helper functions
    // -------------------------------------------------------------------------

    // Byte-enable pattern of an access of the given size at lane offset 0.
    function automatic logic [BE_W-1:0] size_be(input logic [1:0] size);
        logic [BE_W-1:0] be;
        be = '0;
        case (size)
            2'b00:   be[0]   = 1'b1;
            2'b01:   be[1:0] = 2'b11;
            2'b10:   be[3:0] = 4'b1111;
            2'b11:   be      = '1;
            default: be      = '0;
        endcase
        return be;
    endfunction

    // Bit mask covering the low 8/16/32/64 data bits of an access.
    function automatic logic [XLEN-1:0] size_mask(input logic [1:0] size);
        logic [XLEN-1:0] m;
        m = '0;
        case (size)
            2'b00:   m[7:0]  = 8'hFF;
            2'b01:   m[15:0] = 16'hFFFF;
            2'b10:   m[31:0] = 32'hFFFF_FFFF;
            2'b11:   m       = '1;
            default: m       = '0;
        endcase
        return m;
    endfunction

    // Natural alignment check on the low address bits.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] a);
        logic bad;
        case (size)
            2'b00:   bad = 1'b0;
            2'b01:   bad = a[0];
            2'b10:   bad = (a[1:0] != 2'b00);
            2'b11:   bad = (a != 3'b000);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    // Sign- or zero-extend a right-justified load value from its access width.
    function automatic logic [XLEN-1:0] extend_load(input logic [XLEN-1:0] raw,
                                                    input logic [1:0]      size,
                                                    input logic            sext);
        logic [XLEN-1:0] res;
        int              w;
        w = 8 << size;
        if (w > XLEN) begin
            w = XLEN;
        end else begin
            w = w;
        end
        res = raw;
        for (int i = 0; i < XLEN; i++) begin
            if (i >= w) begin
                res[i] = sext & raw[w-1];
            end else begin
                res[i] = raw[i];
            end
        end
        return res;
    endfunction

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_e            state_q,     state_d;
    logic [CNT_W-1:0]  cnt_q,       cnt_d;
    logic [ADDR_W-1:0] bus_addr_q,  bus_addr_d;
    logic              bus_rd_en_q, bus_rd_en_d;
    logic              bus_wr_en_q, bus_wr_en_d;
    logic [BE_W-1:0]   bus_be_q,    bus_be_d;
    logic [XLEN-1:0]   bus_wdata_q, bus_wdata_d;
    logic [OFF_W-1:0]  off_q,       off_d;
    logic [1:0]        size_q,      size_d;
    logic              sext_q,      sext_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [XLEN-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic [1:0]        rsp_err_q,   rsp_err_d;

    logic              req_bad_s;
    logic              timeout_hit_s;
    logic [OFF_W-1:0]  req_off_s;
    logic [XLEN-1:0]   rdata_shift_s;

    // Request decode, timeout detection and load-lane extraction.
    always_comb begin
        req_off_s     = req_addr[OFF_W-1:0];
        req_bad_s     = is_misaligned(req_size, req_addr[2:0]) ||
                        ((req_size == 2'b11) && (XLEN == 32));
        timeout_hit_s = (TIMEOUT > 0) && (cnt_q == CNT_W'(TIMEOUT - 1));
        rdata_shift_s = bus_rdata >> {off_q, 3'b000};
    end

    // Next-state and next-output logic of the IDLE/BUS/RESP sequencer.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bus_addr_d  = bus_addr_q;
        bus_rd_en_d = bus_rd_en_q;
        bus_wr_en_d = bus_wr_en_q;
        bus_be_d    = bus_be_q;
        bus_wdata_d = bus_wdata_q;
        off_d       = off_q;
        size_d      = size_q;
        sext_d      = sext_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    off_d  = req_off_s;
                    size_d = req_size;
                    sext_d = req_sign_ext;
                    if (req_bad_s) begin
                        // Rejected without touching the bus.
                        state_d     = ST_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = ERR_ALIGN;
                        rsp_rdata_d = '0;
                    end else begin
                        state_d     = ST_BUS;
                        cnt_d       = '0;
                        bus_addr_d  = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                        bus_be_d    = size_be(req_size) << req_off_s;
                        bus_wdata_d = (req_wdata & size_mask(req_size)) << {req_off_s, 3'b000};
                        bus_wr_en_d = req_wr;
                        bus_rd_en_d = ~req_wr;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_BUS: begin
                cnt_d = cnt_q + CNT_W'(1);
                // Ack has priority over a timeout in the same cycle.
                if (bus_ack || timeout_hit_s) begin
                    state_d     = ST_RESP;
                    rsp_valid_d = 1'b1;
                    bus_rd_en_d = 1'b0;
                    bus_wr_en_d = 1'b0;
                    bus_addr_d  = '0;
                    bus_be_d    = '0;
                    bus_wdata_d = '0;
                    if (bus_ack) begin
                        rsp_err_d   = ERR_OK;
                        rsp_rdata_d = bus_rd_en_q ? extend_load(rdata_shift_s & size_mask(size_q),
                                                                size_q, sext_q)
                                                  : '0;
                    end else begin
                        rsp_err_d   = ERR_TIMEOUT;
                        rsp_rdata_d = '0;
                    end
                end else begin
                    state_d = ST_BUS;
                end
            end

            ST_RESP: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d     = ST_IDLE;
                bus_rd_en_d = 1'b0;
                bus_wr_en_d = 1'b0;
            end
        endcase
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            bus_addr_q  <= '0;
            bus_rd_en_q <= 1'b0;
            bus_wr_en_q <= 1'b0;
            bus_be_q    <= '0;
            bus_wdata_q <= '0;
            off_q       <= '0;
            size_q      <= 2'b00;
            sext_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 2'b00;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bus_addr_q  <= bus_addr_d;
            bus_rd_en_q <= bus_rd_en_d;
            bus_wr_en_q <= bus_wr_en_d;
            bus_be_q    <= bus_be_d;
            bus_wdata_q <= bus_wdata_d;
            off_q       <= off_d;
            size_q      <= size_d;
            sext_q      <= sext_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign bus_addr  = bus_addr_q;
    assign bus_rd_en = bus_rd_en_q;
    assign bus_wr_en = bus_wr_en_q;
    assign bus_be    = bus_be_q;
    assign bus_wdata = bus_wdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_core_lsu.sv
// -----------------------------------------------------------------------------
// tb_core_lsu : self-checking bench for core_lsu.
// Instance a: XLEN=32, TIMEOUT=4. Instance b: XLEN=64, TIMEOUT=15.
// Expected values come from a byte-arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_core_lsu;
    localparam int TO32 = 4;
    localparam int TO64 = 15;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Instance a (XLEN=32)
    logic        a_req_valid = 1'b0, a_req_wr = 1'b0, a_req_sign_ext = 1'b0;
    logic [1:0]  a_req_size  = 2'b00;
    logic [31:0] a_req_addr  = 32'h0, a_req_wdata = 32'h0;
    logic        a_req_ready, a_bus_rd_en, a_bus_wr_en, a_rsp_valid;
    logic [31:0] a_bus_addr, a_bus_wdata, a_rsp_rdata;
    logic [3:0]  a_bus_be;
    logic [31:0] a_bus_rdata = 32'h0;
    logic        a_bus_ack = 1'b0;
    logic [1:0]  a_rsp_err;

    // Instance b (XLEN=64)
    logic        b_req_valid = 1'b0, b_req_wr = 1'b0, b_req_sign_ext = 1'b0;
    logic [1:0]  b_req_size  = 2'b00;
    logic [31:0] b_req_addr  = 32'h0;
    logic [63:0] b_req_wdata = 64'h0;
    logic        b_req_ready, b_bus_rd_en, b_bus_wr_en, b_rsp_valid;
    logic [31:0] b_bus_addr;
    logic [63:0] b_bus_wdata, b_rsp_rdata;
    logic [7:0]  b_bus_be;
    logic [63:0] b_bus_rdata = 64'h0;
    logic        b_bus_ack = 1'b0;
    logic [1:0]  b_rsp_err;

    core_lsu #(.XLEN(32), .ADDR_W(32), .TIMEOUT(TO32)) u_a (
        .clk(clk), .rst(rst),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_wr(a_req_wr),
        .req_size(a_req_size), .req_sign_ext(a_req_sign_ext), .req_addr(a_req_addr),
        .req_wdata(a_req_wdata), .bus_addr(a_bus_addr), .bus_rd_en(a_bus_rd_en),
        .bus_wr_en(a_bus_wr_en), .bus_be(a_bus_be), .bus_wdata(a_bus_wdata),
        .bus_rdata(a_bus_rdata), .bus_ack(a_bus_ack), .rsp_valid(a_rsp_valid),
        .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err)
    );

    core_lsu #(.XLEN(64), .ADDR_W(32), .TIMEOUT(TO64)) u_b (
        .clk(clk), .rst(rst),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_wr(b_req_wr),
        .req_size(b_req_size), .req_sign_ext(b_req_sign_ext), .req_addr(b_req_addr),
        .req_wdata(b_req_wdata), .bus_addr(b_bus_addr), .bus_rd_en(b_bus_rd_en),
        .bus_wr_en(b_bus_wr_en), .bus_be(b_bus_be), .bus_wdata(b_bus_wdata),
        .bus_rdata(b_bus_rdata), .bus_ack(b_bus_ack), .rsp_valid(b_rsp_valid),
        .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err)
    );

    // Reference model: byte-level arithmetic on 64-bit integers.
    function automatic void model(input int xlen, input bit wr, input bit [1:0] size,
                                  input bit sext, input longint unsigned addr,
                                  input longint unsigned wdata, input longint unsigned rdata,
                                  output bit bad, output longint unsigned be,
                                  output longint unsigned bwd, output longint unsigned rres);
        longint unsigned nb, off, bits, mask, v;
        nb   = 64'd1 << size;
        off  = addr % 64'(xlen / 8);
        bits = 64'd8 * nb;
        bad  = ((size == 2'd3) && (xlen == 32)) || ((addr % nb) != 64'd0);
        be   = ((64'd1 << nb) - 64'd1) << off;
        mask = (bits == 64'd64) ? ~64'd0 : ((64'd1 << bits) - 64'd1);
        bwd  = (wdata & mask) << (64'd8 * off);
        v    = (rdata >> (64'd8 * off)) & mask;
        if (sext && (bits < 64'd64) && (v >= (64'd1 << (bits - 64'd1))))
            v = v - (64'd1 << bits);
        rres = wr ? 64'd0 : v;
        if (xlen == 32) begin
            bwd  = bwd & 64'hFFFF_FFFF;
            rres = rres & 64'hFFFF_FFFF;
        end
    endfunction

    // One complete access on instance a; ack after wait_cyc BUS cycles.
    task automatic run32(input bit wr, input bit [1:0] size, input bit sext,
                         input bit [31:0] addr, input bit [31:0] wdata,
                         input bit [31:0] rdata, input int wait_cyc, input string name);
        bit bad, timed_out, done;
        longint unsigned ebe, ewd, erd;
        bit [31:0] exp_rd;
        bit [1:0]  exp_err;
        int k;
        model(32, wr, size, sext, 64'(addr), 64'(wdata), 64'(rdata), bad, ebe, ewd, erd);
        @(negedge clk);
        checks++;
        if (a_req_ready !== 1'b1) begin errors++; $display("FAIL %s ready_idle: got %b exp 1", name, a_req_ready); end
        a_req_valid = 1'b1; a_req_wr = wr; a_req_size = size; a_req_sign_ext = sext;
        a_req_addr = addr; a_req_wdata = wdata;
        @(negedge clk);
        a_req_valid = 1'b0; a_req_wr = $urandom; a_req_size = 2'($urandom);
        a_req_addr = $urandom; a_req_wdata = $urandom; a_req_sign_ext = $urandom;
        if (bad) begin
            exp_err = 2'b01; exp_rd = 32'h0;
            checks++;
            if ({a_bus_rd_en, a_bus_wr_en} !== 2'b00) begin errors++; $display("FAIL %s no_strobe: got %b exp 00", name, {a_bus_rd_en, a_bus_wr_en}); end
        end else begin
            checks++;
            if (a_bus_addr !== (addr & 32'hFFFF_FFFC)) begin errors++; $display("FAIL %s bus_addr: got %h exp %h", name, a_bus_addr, addr & 32'hFFFF_FFFC); end
            checks++;
            if (a_bus_be !== 4'(ebe)) begin errors++; $display("FAIL %s bus_be: got %b exp %b", name, a_bus_be, 4'(ebe)); end
            if (wr) begin
                checks++;
                if (a_bus_wdata !== 32'(ewd)) begin errors++; $display("FAIL %s bus_wdata: got %h exp %h", name, a_bus_wdata, 32'(ewd)); end
            end
            k = 0; done = 1'b0; timed_out = 1'b0;
            while (!done) begin
                checks++;
                if ({a_bus_wr_en, a_bus_rd_en, a_req_ready} !== {wr, !wr, 1'b0}) begin
                    errors++; $display("FAIL %s strobe_held cyc%0d: got %b exp %b", name, k, {a_bus_wr_en, a_bus_rd_en, a_req_ready}, {wr, !wr, 1'b0});
                end
                a_bus_ack   = (k == wait_cyc);
                a_bus_rdata = (k == wait_cyc) ? rdata : 32'($urandom);
                timed_out   = (k == TO32 - 1) && (k != wait_cyc);
                done        = (k == wait_cyc) || (k == TO32 - 1);
                @(negedge clk);
                k++;
            end
            a_bus_ack = 1'b0;
            exp_err = timed_out ? 2'b10 : 2'b00;
            exp_rd  = timed_out ? 32'h0 : 32'(erd);
            checks++;
            if ({a_bus_rd_en, a_bus_wr_en} !== 2'b00) begin errors++; $display("FAIL %s strobe_drop: got %b exp 00", name, {a_bus_rd_en, a_bus_wr_en}); end
        end
        checks++;
        if (a_rsp_valid !== 1'b1) begin errors++; $display("FAIL %s rsp_valid: got %b exp 1", name, a_rsp_valid); end
        checks++;
        if (a_rsp_err !== exp_err) begin errors++; $display("FAIL %s rsp_err: got %b exp %b", name, a_rsp_err, exp_err); end
        checks++;
        if (a_rsp_rdata !== exp_rd) begin errors++; $display("FAIL %s rsp_rdata: got %h exp %h", name, a_rsp_rdata, exp_rd); end
        @(negedge clk);
        checks++;
        if ({a_rsp_valid, a_req_ready} !== 2'b01) begin errors++; $display("FAIL %s rsp_pulse_end: got %b exp 01", name, {a_rsp_valid, a_req_ready}); end
        checks++;
        if (a_rsp_rdata !== exp_rd) begin errors++; $display("FAIL %s rsp_hold: got %h exp %h", name, a_rsp_rdata, exp_rd); end
    endtask

    // One complete access on instance b; wait_cyc stays below its timeout.
    task automatic run64(input bit wr, input bit [1:0] size, input bit sext,
                         input bit [31:0] addr, input bit [63:0] wdata,
                         input bit [63:0] rdata, input int wait_cyc, input string name);
        bit bad;
        longint unsigned ebe, ewd, erd;
        model(64, wr, size, sext, 64'(addr), wdata, rdata, bad, ebe, ewd, erd);
        @(negedge clk);
        b_req_valid = 1'b1; b_req_wr = wr; b_req_size = size; b_req_sign_ext = sext;
        b_req_addr = addr; b_req_wdata = wdata;
        @(negedge clk);
        b_req_valid = 1'b0;
        if (!bad) begin
            checks++;
            if (b_bus_addr !== (addr & 32'hFFFF_FFF8)) begin errors++; $display("FAIL %s bus_addr: got %h exp %h", name, b_bus_addr, addr & 32'hFFFF_FFF8); end
            checks++;
            if (b_bus_be !== 8'(ebe)) begin errors++; $display("FAIL %s bus_be: got %b exp %b", name, b_bus_be, 8'(ebe)); end
            if (wr) begin
                checks++;
                if (b_bus_wdata !== ewd) begin errors++; $display("FAIL %s bus_wdata: got %h exp %h", name, b_bus_wdata, ewd); end
            end
            for (int k = 0; k <= wait_cyc; k++) begin
                checks++;
                if ({b_bus_wr_en, b_bus_rd_en} !== {wr, !wr}) begin errors++; $display("FAIL %s strobe_held cyc%0d: got %b", name, k, {b_bus_wr_en, b_bus_rd_en}); end
                b_bus_ack   = (k == wait_cyc);
                b_bus_rdata = (k == wait_cyc) ? rdata : {$urandom, $urandom};
                @(negedge clk);
            end
            b_bus_ack = 1'b0;
        end
        checks++;
        if (b_rsp_valid !== 1'b1) begin errors++; $display("FAIL %s rsp_valid: got %b exp 1", name, b_rsp_valid); end
        checks++;
        if (b_rsp_err !== (bad ? 2'b01 : 2'b00)) begin errors++; $display("FAIL %s rsp_err: got %b exp %b", name, b_rsp_err, bad ? 2'b01 : 2'b00); end
        checks++;
        if (b_rsp_rdata !== (bad ? 64'h0 : erd)) begin errors++; $display("FAIL %s rsp_rdata: got %h exp %h", name, b_rsp_rdata, bad ? 64'h0 : erd); end
        @(negedge clk);
        checks++;
        if ({b_rsp_valid, b_req_ready} !== 2'b01) begin errors++; $display("FAIL %s rsp_pulse_end: got %b exp 01", name, {b_rsp_valid, b_req_ready}); end
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({a_req_ready, a_bus_rd_en, a_bus_wr_en, a_rsp_valid} !== 4'b1000) begin errors++; $display("FAIL reset_ctrl: got %b exp 1000", {a_req_ready, a_bus_rd_en, a_bus_wr_en, a_rsp_valid}); end
        checks++;
        if ({a_bus_addr, a_bus_be, a_bus_wdata, a_rsp_rdata, a_rsp_err} !== 102'h0) begin errors++; $display("FAIL reset_data: got nonzero bus/rsp fields"); end
        checks++;
        if ({b_req_ready, b_bus_rd_en, b_bus_wr_en, b_rsp_valid, b_bus_be, b_rsp_err} !== 14'b10_0000_0000_0000) begin errors++; $display("FAIL reset_b: got %b", {b_req_ready, b_bus_rd_en, b_bus_wr_en, b_rsp_valid, b_bus_be, b_rsp_err}); end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_directed32();
        run32(1'b0, 2'b00, 1'b1, 32'h0000_1003, 32'h0, 32'h80FF_FF12, 2, "load_byte_sext");
        run32(1'b1, 2'b01, 1'b0, 32'h0000_2002, 32'h0000_ABCD, 32'h0, 0, "store_half");
        run32(1'b0, 2'b10, 1'b0, 32'h0000_0006, 32'h0, 32'h0, 0, "misaligned_word");
        run32(1'b0, 2'b11, 1'b0, 32'h0000_0000, 32'h0, 32'h0, 0, "illegal_double");
        run32(1'b0, 2'b01, 1'b0, 32'h0000_0012, 32'h0, 32'h89AB_CDEF, 1, "load_half_zext");
    endtask

    task automatic test_timeout();
        run32(1'b0, 2'b10, 1'b0, 32'h0000_0040, 32'h0, 32'h1234_5678, 100, "timeout_no_ack");
        run32(1'b0, 2'b10, 1'b0, 32'h0000_0040, 32'h0, 32'h1234_5678, TO32 - 1, "ack_on_last");
        run32(1'b1, 2'b00, 1'b0, 32'h0000_0041, 32'h0000_00A5, 32'h0, 100, "store_timeout");
    endtask

    task automatic test_xlen64();
        run64(1'b0, 2'b11, 1'b0, 32'h0000_0008, 64'h0, 64'h0123_4567_89AB_CDEF, 0, "b_load_double");
        run64(1'b0, 2'b10, 1'b0, 32'h0000_000C, 64'h0, 64'h0123_4567_89AB_CDEF, 0, "b_load_word_zext");
        run64(1'b0, 2'b10, 1'b1, 32'h0000_0008, 64'h0, 64'h0123_4567_89AB_CDEF, 2, "b_load_word_sext");
        run64(1'b1, 2'b01, 1'b0, 32'h0000_0016, 64'hFFFF_FFFF_FFFF_1234, 64'h0, 1, "b_store_half");
        run64(1'b0, 2'b11, 1'b0, 32'h0000_0004, 64'h0, 64'h0, 0, "b_misaligned_double");
    endtask

    task automatic test_ack_outside_bus();
        @(negedge clk);
        a_bus_ack = 1'b1; a_bus_rdata = 32'hDEAD_BEEF;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if ({a_rsp_valid, a_req_ready, a_bus_rd_en} !== 3'b010) begin errors++; $display("FAIL stray_ack: got %b exp 010", {a_rsp_valid, a_req_ready, a_bus_rd_en}); end
        end
        a_bus_ack = 1'b0;
    endtask

    task automatic test_reset_mid_access();
        @(negedge clk);
        a_req_valid = 1'b1; a_req_wr = 1'b0; a_req_size = 2'b10; a_req_addr = 32'h0000_0100;
        @(negedge clk);
        a_req_valid = 1'b0;
        checks++;
        if (a_bus_rd_en !== 1'b1) begin errors++; $display("FAIL rst_mid_pre: rd_en got %b exp 1", a_bus_rd_en); end
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({a_bus_rd_en, a_bus_wr_en, a_req_ready} !== 3'b001) begin errors++; $display("FAIL rst_mid_async: got %b exp 001", {a_bus_rd_en, a_bus_wr_en, a_req_ready}); end
        @(negedge clk);
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if ({a_rsp_valid, a_req_ready} !== 2'b01) begin errors++; $display("FAIL rst_mid_no_rsp: got %b exp 01", {a_rsp_valid, a_req_ready}); end
        end
        run32(1'b0, 2'b00, 1'b0, 32'h0000_0101, 32'h0, 32'h0000_F700, 1, "after_reset");
    endtask

    task automatic test_random();
        bit [31:0] addr;
        for (int i = 0; i < 30; i++) begin
            addr = 32'($urandom_range(0, 255));
            run32(1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom), addr,
                  32'($urandom), 32'($urandom), $urandom_range(0, 5), "rand32");
        end
        for (int i = 0; i < 10; i++) begin
            addr = 32'($urandom_range(0, 255));
            run64(1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom), addr,
                  {$urandom, $urandom}, {$urandom, $urandom}, $urandom_range(0, 4), "rand64");
        end
    endtask

    initial begin
        test_reset();
        test_directed32();
        test_timeout();
        test_xlen64();
        test_ack_outside_bus();
        test_reset_mid_access();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
